// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scanner.
// Each digit gets a blanking gap and then a lit window. The digit, DP, blink and
// leading-zero inputs are captured once per frame. Blinking and a live display
// enable can turn the current digit off.
module seg_scan_ctrl #(
    parameter int unsigned BLANK_CYC = 1,
    parameter int unsigned SHOW_CYC  = 4,
    parameter int unsigned BLINK_DIV = 50
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        disp_en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [1:0]  sel,
    output logic        frame_done
);

    localparam int unsigned MAXC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] LAST_SHOW  = CW'(SHOW_CYC - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_DIV - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_phase, w_phase_nxt;

    logic [15:0]   r_snap_digits, w_snap_digits;
    logic [3:0]    r_snap_dp, w_snap_dp;
    logic [3:0]    r_snap_blink, w_snap_blink;
    logic          r_snap_lz, w_snap_lz;
    logic          w_take;

    logic [3:0]    r_an_n, w_an_nxt;
    logic [6:0]    r_seg_n, w_seg_nxt;
    logic          r_dp_n, w_dp_nxt;
    logic          r_frame_done, w_frame_nxt;

    logic [3:0]    w_code;
    logic [3:0]    w_lz_blank;
    logic          w_blanked;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
        return pat;
    endfunction

    // Next-state, blink timing and next output values. The outputs are computed
    // from the post-edge state and snapshot, so they are registered and line up
    // with the state they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_sel_nxt   = r_sel;
        w_frame_nxt = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == LAST_BLANK) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == LAST_SHOW) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = r_sel + 2'd1;
                    w_frame_nxt = (r_sel == 2'd3);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase

        w_bcnt_nxt  = r_bcnt + 1'b1;
        w_phase_nxt = r_phase;
        if (r_bcnt == LAST_BLINK) begin
            w_bcnt_nxt  = '0;
            w_phase_nxt = ~r_phase;
        end

        w_take        = (r_state == ST_BLANK) && (r_sel == 2'd0) && (r_cnt == '0);
        w_snap_digits = w_take ? digits     : r_snap_digits;
        w_snap_dp     = w_take ? dp_in      : r_snap_dp;
        w_snap_blink  = w_take ? blink_mask : r_snap_blink;
        w_snap_lz     = w_take ? lz_en      : r_snap_lz;

        w_code        = w_snap_digits[{w_sel_nxt, 2'b00} +: 4];
        w_lz_blank[3] = w_snap_lz & (w_snap_digits[15:12] == 4'h0);
        w_lz_blank[2] = w_lz_blank[3] & (w_snap_digits[11:8] == 4'h0);
        w_lz_blank[1] = w_lz_blank[2] & (w_snap_digits[7:4] == 4'h0);
        w_lz_blank[0] = 1'b0;
        w_blanked     = w_lz_blank[w_sel_nxt] | (w_phase_nxt & w_snap_blink[w_sel_nxt]);

        w_an_nxt  = '1;
        w_seg_nxt = '1;
        w_dp_nxt  = 1'b1;
        if ((w_state_nxt == ST_SHOW) && disp_en && !w_blanked) begin
            w_an_nxt  = ~(4'b0001 << w_sel_nxt);
            w_seg_nxt = f_decode(w_code);
            w_dp_nxt  = ~w_snap_dp[w_sel_nxt];
        end
    end

    // Scan FSM, digit index and blink counter.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Per-frame input snapshot.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_snap_digits <= '0;
            r_snap_dp     <= '0;
            r_snap_blink  <= '0;
            r_snap_lz     <= 1'b0;
        end else begin
            r_snap_digits <= w_snap_digits;
            r_snap_dp     <= w_snap_dp;
            r_snap_blink  <= w_snap_blink;
            r_snap_lz     <= w_snap_lz;
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_an_n       <= '1;
            r_seg_n      <= '1;
            r_dp_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_an_nxt;
            r_seg_n      <= w_seg_nxt;
            r_dp_n       <= w_dp_nxt;
            r_frame_done <= w_frame_nxt;
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign sel        = r_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and randomized checks of seg_scan_ctrl against a
// timeline model. The model derives the expected output from the cycle number
// since reset and from a per-frame capture of the inputs.
module tb_seg_scan_ctrl;

    localparam int BLANK_CYC = 1;
    localparam int SHOW_CYC  = 4;
    localparam int BLINK_DIV = 50;
    localparam int PERIOD    = BLANK_CYC + SHOW_CYC;
    localparam int FRAME     = 4 * PERIOD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_en = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        lz_en = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  sel;
    logic        frame_done;

    seg_scan_ctrl #(
        .BLANK_CYC (BLANK_CYC),
        .SHOW_CYC  (SHOW_CYC),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk_100    (clk),
        .rst        (rst),
        .disp_en    (disp_en),
        .digits     (digits),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .sel        (sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          t        = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_dp     = '0;
    logic [3:0]  m_mask   = '0;
    logic        m_lz     = 1'b0;
    logic        prev_en  = 1'b1;

    function automatic logic [6:0] ref_seg(input int code);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (code > 9) return 7'h3F;
        return tbl[code];
    endfunction

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    endtask

    // Reset held for n edges; outputs checked after each reset edge.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("rst_an_n", 32'(an_n), 32'hF);
            check("rst_seg_n", 32'(seg_n), 32'h7F);
            check("rst_dp_n", 32'(dp_n), 32'h1);
            check("rst_sel", 32'(sel), 32'h0);
            check("rst_frame_done", 32'(frame_done), 32'h0);
        end
        rst = 1'b0;
        t = 0;
    endtask

    // Check cycle t against the model, capture inputs at frame start, advance.
    task automatic run_cycle();
        int          pos, d, w, code;
        logic        blanked, skip_seg;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        pos = t % FRAME;
        d   = pos / PERIOD;
        w   = pos % PERIOD;
        e_fd = (pos == 0) && (t != 0);
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; skip_seg = 1'b0;
        if (w >= BLANK_CYC) begin
            code    = int'((m_digits >> (4 * d)) & 16'hF);
            blanked = (m_lz && d >= 1 && (m_digits >> (4 * d)) == 16'h0) ||
                      (((t / BLINK_DIV) % 2) == 1 && m_mask[d]);
            if (!prev_en) begin
                // display off: everything dark
            end else if (blanked) begin
                skip_seg = 1'b1;
            end else begin
                e_an  = ~(4'b0001 << d);
                e_seg = ref_seg(code);
                e_dp  = ~m_dp[d];
            end
        end
        check("an_n", 32'(an_n), 32'(e_an));
        if (!skip_seg) check("seg_n", 32'(seg_n), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("sel", 32'(sel), 32'(d));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        if (pos == 0) begin
            m_digits = digits;
            m_dp     = dp_in;
            m_mask   = blink_mask;
            m_lz     = lz_en;
        end
        prev_en = disp_en;
        t++;
        @(negedge clk);
    endtask

    task automatic run_until(input int p);
        while ((t % FRAME) != p) run_cycle();
    endtask

    initial begin
        // Basic scan of 1234, first frame pulse at cycle 20.
        digits = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0000; lz_en = 1'b0; disp_en = 1'b1;
        do_reset(2);
        repeat (47) run_cycle();

        // Input change during SHOW of digit 1 takes effect next frame only.
        digits = 16'h9999; dp_in = 4'b1010;
        run_until(0);
        repeat (FRAME) run_cycle();

        // Leading-zero suppression patterns.
        lz_en = 1'b1; digits = 16'h0045; dp_in = 4'b1111;
        repeat (FRAME) run_cycle();
        digits = 16'h0000; dp_in = 4'b0101;
        repeat (FRAME) run_cycle();
        digits = 16'h0A00; dp_in = 4'b0000;
        repeat (FRAME) run_cycle();
        for (int f = 0; f < 8; f++) begin
            digits = rand_digits(); dp_in = 4'($urandom_range(0, 15));
            lz_en = 1'($urandom_range(0, 1));
            repeat (FRAME) run_cycle();
        end

        // Dash codes.
        lz_en = 1'b0; digits = 16'hFCBA; dp_in = 4'b0001;
        repeat (FRAME) run_cycle();

        // Blink on digit 0 from reset across several half-periods.
        blink_mask = 4'b0001; digits = 16'h5678; dp_in = 4'b0001;
        do_reset(1);
        repeat (160) run_cycle();

        // Display disable starting in SHOW of digit 2.
        blink_mask = 4'b0000;
        run_until(11);
        disp_en = 1'b0;
        repeat (30) run_cycle();
        disp_en = 1'b1;
        repeat (25) run_cycle();

        // Fully random inputs every cycle.
        for (int i = 0; i < 300; i++) begin
            digits     = rand_digits();
            dp_in      = 4'($urandom_range(0, 15));
            blink_mask = 4'($urandom_range(0, 15));
            lz_en      = 1'($urandom_range(0, 1));
            disp_en    = ($urandom_range(0, 3) != 0);
            run_cycle();
        end

        // Reset during SHOW of digit 2, then digit 0 first with a dash.
        disp_en = 1'b1; blink_mask = 4'b0000; lz_en = 1'b0; digits = 16'h321A; dp_in = 4'b0000;
        run_until(12);
        do_reset(1);
        repeat (25) run_cycle();

        // Reset on the last cycle of a frame suppresses the pending pulse.
        run_until(19);
        do_reset(1);
        repeat (45) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
